cp0_exception_unit: RTL and testbench

Coprocessor-0 and exception-sequencing stage sitting directly downstream of the instruction decoder in the Minisys-1A CPU. It consumes the decoder's trap and CP0 strobes (Break, Syscall, Eret, Reserved_instruction, Mfc0, Mtc0) plus ALU overflow and external interrupt lines. It holds Status, Cause and EPC. On an accepted event it issues a registered one-cycle PC redirect to the fetch stage.

---
 rtl/minisys_cp0_pkg.sv | 26 ++
 rtl/int_sync.sv | 27 ++
 rtl/cp0_exception_unit.sv | 151 +++++++++++++++
 tb/tb_cp0_exception_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/minisys_cp0_pkg.sv
// Shared definitions for the Minisys-1A CP0 / exception stage: register indices,
// exception codes, Status/Cause field positions and the sequencing FSM states.
package minisys_cp0_pkg;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  localparam int ST_IE      = 0;
  localparam int ST_EXL     = 1;
  localparam int ST_IM_LO   = 10;
  localparam int CA_CODE_LO = 2;
  localparam int CA_IP_LO   = 10;

  typedef enum logic {
    S_RUN      = 1'b0,
    S_REDIRECT = 1'b1
  } state_e;

endpackage

// File: rtl/int_sync.sv
// Two-flop synchronizer bringing the asynchronous interrupt request lines
// into the clock domain.
module int_sync #(
  parameter int W = 6
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] sync_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/cp0_exception_unit.sv
// CP0 register file (Status/Cause/EPC) and exception sequencer. Accepted events
// produce a registered one-cycle redirect to the fetch stage.
module cp0_exception_unit
  import minisys_cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_F000,
  parameter logic [31:0] STATUS_RESET = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        instr_valid,
  input  logic [31:0] pc,
  input  logic        Break,
  input  logic        Syscall,
  input  logic        Eret,
  input  logic        Reserved_instruction,
  input  logic        Mfc0,
  input  logic        Mtc0,
  input  logic        overflow,
  input  logic [4:0]  cp0_sel,
  input  logic [31:0] cp0_wdata,
  input  logic [5:0]  ext_int,
  output logic [31:0] cp0_rdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        exl
);

  logic [5:0]  ip;
  state_e      state_q, state_d;
  logic        ie_q, ie_d;
  logic        exl_q, exl_d;
  logic [5:0]  im_q, im_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] rpc_q, rpc_d;
  logic        red_q, red_d;

  logic        accept;
  logic        int_pend;
  logic        exc_take;
  logic        exc_is_int;
  logic [4:0]  exc_code;

  // Reads are combinational regardless of the Mfc0 strobe.
  logic unused_mfc0;
  assign unused_mfc0 = Mfc0;

  int_sync #(.W(6)) u_int_sync (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .async_i(ext_int),
    .sync_o (ip)
  );

  always_comb begin
    accept     = (state_q == S_RUN) && instr_valid;
    int_pend   = ie_q & ~exl_q & (|(ip & im_q));
    exc_take   = 1'b1;
    exc_is_int = 1'b0;
    exc_code   = EXC_INT;
    if (Reserved_instruction)  exc_code = EXC_RI;
    else if (Break)            exc_code = EXC_BP;
    else if (Syscall)          exc_code = EXC_SYS;
    else if (overflow)         exc_code = EXC_OV;
    else if (int_pend)         exc_is_int = 1'b1;
    else                       exc_take = 1'b0;
  end

  always_comb begin
    state_d = S_RUN;
    ie_d    = ie_q;
    exl_d   = exl_q;
    im_d    = im_q;
    code_d  = code_q;
    epc_d   = epc_q;
    rpc_d   = rpc_q;
    red_d   = 1'b0;
    if (accept && exc_take) begin
      // A nested exception keeps the EPC of the outermost one.
      if (!exl_q) epc_d = exc_is_int ? (pc + 32'd4) : pc;
      code_d  = exc_code;
      exl_d   = 1'b1;
      rpc_d   = EXC_VECTOR;
      red_d   = 1'b1;
      state_d = S_REDIRECT;
    end else if (accept) begin
      if (Mtc0) begin
        case (cp0_sel)
          CP0_STATUS: begin
            im_d  = cp0_wdata[ST_IM_LO +: 6];
            exl_d = cp0_wdata[ST_EXL];
            ie_d  = cp0_wdata[ST_IE];
          end
          CP0_EPC: epc_d = cp0_wdata;
          default: ;
        endcase
      end
      if (Eret) begin
        exl_d   = 1'b0;
        rpc_d   = epc_q;
        red_d   = 1'b1;
        state_d = S_REDIRECT;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RUN;
      ie_q    <= STATUS_RESET[ST_IE];
      exl_q   <= STATUS_RESET[ST_EXL];
      im_q    <= STATUS_RESET[ST_IM_LO +: 6];
      code_q  <= '0;
      epc_q   <= '0;
      rpc_q   <= '0;
      red_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ie_q    <= ie_d;
      exl_q   <= exl_d;
      im_q    <= im_d;
      code_q  <= code_d;
      epc_q   <= epc_d;
      rpc_q   <= rpc_d;
      red_q   <= red_d;
    end
  end

  always_comb begin
    cp0_rdata = '0;
    case (cp0_sel)
      CP0_STATUS: begin
        cp0_rdata[ST_IM_LO +: 6] = im_q;
        cp0_rdata[ST_EXL]        = exl_q;
        cp0_rdata[ST_IE]         = ie_q;
      end
      CP0_CAUSE: begin
        cp0_rdata[CA_IP_LO +: 6]   = ip;
        cp0_rdata[CA_CODE_LO +: 5] = code_q;
      end
      CP0_EPC: cp0_rdata = epc_q;
      default: ;
    endcase
  end

  assign redirect    = red_q;
  assign redirect_pc = rpc_q;
  assign exl         = exl_q;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed bench for cp0_exception_unit: a per-cycle vector table plus a
// hand-written reset-during-redirect sequence.
module tb_cp0_exception_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic [31:0] pc;
  logic        Break, Syscall, Eret, Reserved_instruction, Mfc0, Mtc0, overflow;
  logic [4:0]  cp0_sel;
  logic [31:0] cp0_wdata;
  logic [5:0]  ext_int;
  logic [31:0] cp0_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        exl;

  always #5 clock = ~clock;

  cp0_exception_unit dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .instr_valid         (instr_valid),
    .pc                  (pc),
    .Break               (Break),
    .Syscall             (Syscall),
    .Eret                (Eret),
    .Reserved_instruction(Reserved_instruction),
    .Mfc0                (Mfc0),
    .Mtc0                (Mtc0),
    .overflow            (overflow),
    .cp0_sel             (cp0_sel),
    .cp0_wdata           (cp0_wdata),
    .ext_int             (ext_int),
    .cp0_rdata           (cp0_rdata),
    .redirect            (redirect),
    .redirect_pc         (redirect_pc),
    .exl                 (exl)
  );

  // strobe mask order: {RI, Break, Syscall, overflow, Eret, Mtc0}
  localparam logic [5:0] RI = 6'b100000, BP = 6'b010000, SY = 6'b001000;
  localparam logic [5:0] OV = 6'b000100, ER = 6'b000010, MT = 6'b000001;
  localparam logic [5:0] NO = 6'b000000;

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [5:0]  stb;
    logic [4:0]  sel;
    logic [31:0] wd;
    logic [5:0]  ei;
    logic        e_red;
    logic [31:0] e_rpc;
    logic        e_exl;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic iv, input logic [31:0] p, input logic [5:0] stb,
                     input logic [4:0] sel, input logic [31:0] wd, input logic [5:0] ei,
                     input logic e_red, input logic [31:0] e_rpc, input logic e_exl,
                     input logic [31:0] e_rd);
    vec_t v;
    v.iv = iv; v.pc = p; v.stb = stb; v.sel = sel; v.wd = wd; v.ei = ei;
    v.e_red = e_red; v.e_rpc = e_rpc; v.e_exl = e_exl; v.e_rd = e_rd;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] p, input logic [5:0] stb,
                       input logic [4:0] sel, input logic [31:0] wd, input logic [5:0] ei);
    instr_valid          = iv;
    pc                   = p;
    Reserved_instruction = stb[5];
    Break                = stb[4];
    Syscall              = stb[3];
    overflow             = stb[2];
    Eret                 = stb[1];
    Mtc0                 = stb[0];
    Mfc0                 = 1'b0;
    cp0_sel              = sel;
    cp0_wdata            = wd;
    ext_int              = ei;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 32'h0, NO, 5'd0, 32'h0, 6'h0);

    //   iv  pc       strobes  sel   wdata          ext   red  rpc       exl  rdata
    add(0, 32'h000, NO,      5'd12, 32'h0,         6'h0, 0,   32'h0,    0,   32'h0);
    add(0, 32'h000, NO,      5'd13, 32'h0,         6'h0, 0,   32'h0,    0,   32'h0);
    add(0, 32'h000, NO,      5'd14, 32'h0,         6'h0, 0,   32'h0,    0,   32'h0);
    add(1, 32'h100, SY,      5'd14, 32'h0,         6'h0, 1,   32'hF000, 1,   32'h100);
    add(0, 32'h000, NO,      5'd13, 32'h0,         6'h0, 0,   32'h0,    1,   32'h20);
    add(1, 32'h104, ER,      5'd12, 32'h0,         6'h0, 1,   32'h100,  0,   32'h0);
    add(0, 32'h000, NO,      5'd12, 32'h0,         6'h0, 0,   32'h0,    0,   32'h0);
    add(1, 32'h108, MT,      5'd12, 32'h401,       6'h0, 0,   32'h0,    0,   32'h401);
    add(0, 32'h000, NO,      5'd13, 32'h0,         6'h1, 0,   32'h0,    0,   32'h20);
    add(0, 32'h000, NO,      5'd13, 32'h0,         6'h1, 0,   32'h0,    0,   32'h420);
    add(1, 32'h200, NO,      5'd14, 32'h0,         6'h1, 1,   32'hF000, 1,   32'h204);
    add(0, 32'h000, NO,      5'd13, 32'h0,         6'h1, 0,   32'h0,    1,   32'h400);
    add(1, 32'h300, NO,      5'd14, 32'h0,         6'h1, 0,   32'h0,    1,   32'h204);
    add(1, 32'h304, ER,      5'd12, 32'h0,         6'h1, 1,   32'h204,  0,   32'h401);
    add(0, 32'h000, NO,      5'd12, 32'h0,         6'h0, 0,   32'h0,    0,   32'h401);
    add(0, 32'h000, NO,      5'd13, 32'h0,         6'h0, 0,   32'h0,    0,   32'h0);
    add(1, 32'h308, MT,      5'd12, 32'h1,         6'h0, 0,   32'h0,    0,   32'h1);
    add(0, 32'h000, NO,      5'd13, 32'h0,         6'h1, 0,   32'h0,    0,   32'h0);
    add(0, 32'h000, NO,      5'd13, 32'h0,         6'h1, 0,   32'h0,    0,   32'h400);
    add(1, 32'h400, NO,      5'd13, 32'h0,         6'h1, 0,   32'h0,    0,   32'h400);
    add(1, 32'h500, RI|OV|MT,5'd14, 32'hDEAD0000,  6'h1, 1,   32'hF000, 1,   32'h500);
    add(0, 32'h000, NO,      5'd13, 32'h0,         6'h1, 0,   32'h0,    1,   32'h428);
    add(1, 32'h504, ER,      5'd14, 32'h0,         6'h1, 1,   32'h500,  0,   32'h500);
    add(0, 32'h000, NO,      5'd12, 32'h0,         6'h1, 0,   32'h0,    0,   32'h1);
    add(0, 32'h000, OV,      5'd13, 32'h0,         6'h1, 0,   32'h0,    0,   32'h428);
    add(1, 32'h600, BP|SY,   5'd13, 32'h0,         6'h1, 1,   32'hF000, 1,   32'h424);
    add(0, 32'h000, NO,      5'd14, 32'h0,         6'h1, 0,   32'h0,    1,   32'h600);
    add(1, 32'h700, OV,      5'd14, 32'h0,         6'h1, 1,   32'hF000, 1,   32'h600);
    add(1, 32'h800, SY,      5'd13, 32'h0,         6'h1, 0,   32'h0,    1,   32'h430);
    add(0, 32'h000, NO,      5'd13, 32'h0,         6'h1, 0,   32'h0,    1,   32'h430);
    add(0, 32'h000, NO,      5'd5,  32'h0,         6'h1, 0,   32'h0,    1,   32'h0);
    add(1, 32'h900, MT,      5'd13, 32'hFFFFFFFF,  6'h1, 0,   32'h0,    1,   32'h430);

    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].iv, tbl[i].pc, tbl[i].stb, tbl[i].sel, tbl[i].wd, tbl[i].ei);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d.redirect", i), {31'b0, redirect}, {31'b0, tbl[i].e_red});
      chk($sformatf("v%0d.exl", i), {31'b0, exl}, {31'b0, tbl[i].e_exl});
      chk($sformatf("v%0d.rdata", i), cp0_rdata, tbl[i].e_rd);
      if (tbl[i].e_red)
        chk($sformatf("v%0d.redirect_pc", i), redirect_pc, tbl[i].e_rpc);
    end

    // Reset asserted in the middle of a redirect cycle.
    drive(1'b1, 32'hA00, SY, 5'd14, 32'h0, 6'h0);
    @(posedge clock);
    #1;
    chk("rst.pre_redirect", {31'b0, redirect}, 32'd1);
    drive(1'b0, 32'h0, NO, 5'd12, 32'h0, 6'h0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst.redirect", {31'b0, redirect}, 32'd0);
    chk("rst.redirect_pc", redirect_pc, 32'h0);
    chk("rst.exl", {31'b0, exl}, 32'd0);
    chk("rst.status", cp0_rdata, 32'h0);
    cp0_sel = 5'd13;
    #1 chk("rst.cause", cp0_rdata, 32'h0);
    cp0_sel = 5'd14;
    #1 chk("rst.epc", cp0_rdata, 32'h0);
    #1 reset_n = 1'b1;

    drive(1'b0, 32'h0, NO, 5'd13, 32'h0, 6'h0);
    @(posedge clock);
    #1;
    chk("post.redirect", {31'b0, redirect}, 32'd0);
    chk("post.cause", cp0_rdata, 32'h0);
    drive(1'b1, 32'hB00, SY, 5'd14, 32'h0, 6'h0);
    @(posedge clock);
    #1;
    chk("post.sys_redirect", {31'b0, redirect}, 32'd1);
    chk("post.sys_rpc", redirect_pc, 32'hF000);
    chk("post.sys_epc", cp0_rdata, 32'hB00);
    drive(1'b0, 32'h0, NO, 5'd13, 32'h0, 6'h0);
    @(posedge clock);
    #1;
    chk("post.pulse_end", {31'b0, redirect}, 32'd0);
    chk("post.sys_cause", cp0_rdata, 32'h20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
